// File: rtl/dual_update.sv
// dual_update: serial ADMM dual update y+=x-v, g+=u-z with max-residual tracking.
// Define DUAL_UPDATE_SAT_EN to clamp results and report saturation; otherwise results wrap.
module dual_update #(
   parameter int STATE_DIM   = 12,
   parameter int CONTROL_DIM = 4,
   parameter int W           = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [W*STATE_DIM-1:0]   x_k,
   input  logic [W*STATE_DIM-1:0]   v_k,
   input  logic [W*STATE_DIM-1:0]   y_k,
   input  logic [W*CONTROL_DIM-1:0] u_k,
   input  logic [W*CONTROL_DIM-1:0] z_k,
   input  logic [W*CONTROL_DIM-1:0] g_k,
   output logic [W*STATE_DIM-1:0]   y_new,
   output logic [W*CONTROL_DIM-1:0] g_new,
   output logic [W-1:0]             prim_res,
   output logic                     sat_flag,
   output logic                     busy,
   output logic                     done
);
   localparam int IW = $clog2(STATE_DIM + CONTROL_DIM + 1);
   typedef enum logic [1:0] {IDLE, STATE_PASS, CTRL_PASS, FINISH} state_t;
   state_t state;
   logic [IW-1:0] idx;
   logic [W*STATE_DIM-1:0] x_r, v_r, y_r, y_buf;
   logic [W*CONTROL_DIM-1:0] u_r, z_r, g_r, g_buf, g_fin;
   logic [W-1:0] res_max, a, b, c, mag, new_max, r;
   logic [W:0] d, ad;
   logic sat_acc, sat, ctrl, last;
`ifdef DUAL_UPDATE_SAT_EN
   logic [W+1:0] s;
`else
   logic [W-1:0] s;
`endif
   always_comb begin
      ctrl = state == CTRL_PASS;
      a = ctrl ? u_r[idx*W +: W] : x_r[idx*W +: W];
      b = ctrl ? z_r[idx*W +: W] : v_r[idx*W +: W];
      c = ctrl ? g_r[idx*W +: W] : y_r[idx*W +: W];
      d = {a[W-1], a} - {b[W-1], b};
      ad = d[W] ? -d : d;
      // |d| can reach 2^W-1; clamp to the largest positive W-bit value
      mag = (ad[W] | ad[W-1]) ? {1'b0, {(W-1){1'b1}}} : ad[W-1:0];
      new_max = mag > res_max ? mag : res_max;
`ifdef DUAL_UPDATE_SAT_EN
      s = {{2{c[W-1]}}, c} + {d[W], d};
      sat = s[W+1:W-1] != {3{s[W+1]}};
      r = sat ? (s[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : s[W-1:0];
`else
      s = c + d[W-1:0];
      sat = 1'b0;
      r = s;
`endif
      last = idx == (ctrl ? IW'(CONTROL_DIM - 1) : IW'(STATE_DIM - 1));
      g_fin = g_buf;
      g_fin[idx*W +: W] = r;
   end
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         x_r <= x_k;
         v_r <= v_k;
         y_r <= y_k;
         u_r <= u_k;
         z_r <= z_k;
         g_r <= g_k;
      end
      if (state == STATE_PASS) y_buf[idx*W +: W] <= r;
      if (ctrl) g_buf[idx*W +: W] <= r;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         res_max  <= '0;
         sat_acc  <= 1'b0;
         y_new    <= '0;
         g_new    <= '0;
         prim_res <= '0;
         sat_flag <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  res_max <= '0;
                  sat_acc <= 1'b0;
                  idx     <= '0;
                  busy    <= 1'b1;
                  state   <= STATE_PASS;
               end
            end
            STATE_PASS: begin
               res_max <= new_max;
               sat_acc <= sat_acc | sat;
               idx     <= last ? '0 : idx + 1'b1;
               if (last) state <= CTRL_PASS;
            end
            CTRL_PASS: begin
               res_max <= new_max;
               sat_acc <= sat_acc | sat;
               idx     <= last ? '0 : idx + 1'b1;
               // last element is merged directly so outputs are valid during FINISH
               if (last) begin
                  y_new    <= y_buf;
                  g_new    <= g_fin;
                  prim_res <= new_max;
                  sat_flag <= sat_acc | sat;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= FINISH;
               end
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dual_update.sv
// tb_dual_update: scoreboard bench for dual_update; expectations come from an integer model.
module tb_dual_update;
   localparam int W = 16, S = 12, C = 4;
   logic clk = 0, reset = 1, start = 0;
   logic [W*S-1:0] x_k, v_k, y_k, y_new;
   logic [W*C-1:0] u_k, z_k, g_k, g_new;
   logic [W-1:0] prim_res;
   logic sat_flag, busy, done;
   int xs[S], vs[S], ys[S], us[C], zs[C], gs[C];
   int passed = 0, total = 0;
   typedef struct {
      logic [W*S-1:0] y;
      logic [W*C-1:0] g;
      logic [W-1:0] res;
      logic sat;
   } exp_t;
   exp_t sb[$];
   exp_t prev;

   dual_update dut (.clk(clk), .reset(reset), .start(start), .x_k(x_k), .v_k(v_k), .y_k(y_k),
      .u_k(u_k), .z_k(z_k), .g_k(g_k), .y_new(y_new), .g_new(g_new), .prim_res(prim_res),
      .sat_flag(sat_flag), .busy(busy), .done(done));

   always #5 clk = ~clk;

   function automatic logic [W-1:0] step(input int a, input int b, input int c, inout int mx, inout logic sat);
      int d, s, m;
      d = a - b;
      s = c + d;
`ifdef DUAL_UPDATE_SAT_EN
      if (s > 32767) begin s = 32767; sat = 1'b1; end
      else if (s < -32768) begin s = -32768; sat = 1'b1; end
`endif
      m = d < 0 ? -d : d;
      if (m > 32767) m = 32767;
      if (m > mx) mx = m;
      return 16'(s);
   endfunction

   function automatic exp_t model();
      exp_t e;
      int mx = 0;
      logic sat = 1'b0;
      for (int i = 0; i < S; i++) e.y[i*W +: W] = step(xs[i], vs[i], ys[i], mx, sat);
      for (int i = 0; i < C; i++) e.g[i*W +: W] = step(us[i], zs[i], gs[i], mx, sat);
      e.res = 16'(mx);
      e.sat = sat;
      return e;
   endfunction

   task automatic fill(input int x, input int v, input int y, input int u, input int z, input int g);
      for (int i = 0; i < S; i++) begin xs[i] = x; vs[i] = v; ys[i] = y; end
      for (int i = 0; i < C; i++) begin us[i] = u; zs[i] = z; gs[i] = g; end
   endtask

   task automatic pack();
      for (int i = 0; i < S; i++) begin
         x_k[i*W +: W] = 16'(xs[i]); v_k[i*W +: W] = 16'(vs[i]); y_k[i*W +: W] = 16'(ys[i]);
      end
      for (int i = 0; i < C; i++) begin
         u_k[i*W +: W] = 16'(us[i]); z_k[i*W +: W] = 16'(zs[i]); g_k[i*W +: W] = 16'(gs[i]);
      end
   endtask

   // returns at the falling edge of cycle 1 (cycle 0 is the accepting cycle)
   task automatic launch();
      @(negedge clk);
      pack();
      start = 1;
      sb.push_back(model());
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 1;
      while (done !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++; if ({y_new, g_new, prim_res} !== '0) $display("FAIL reset_data got %h want 0", {y_new, g_new, prim_res}); else passed++;
      total++; if ({sat_flag, busy, done} !== 3'b000) $display("FAIL reset_flags got %b want 000", {sat_flag, busy, done}); else passed++;
      reset = 0;
      @(negedge clk);
      total++; if ({busy, done} !== 2'b00) $display("FAIL idle_flags got %b want 00", {busy, done}); else passed++;
   endtask

   task automatic test_basic();
      int cyc;
      exp_t e;
      fill(100, 40, 5, -20, 10, 0);
      launch();
      wait_done(cyc);
      e = sb.pop_front();
      total++; if (cyc !== 17) $display("FAIL basic_latency got %0d want 17", cyc); else passed++;
      total++; if (y_new !== e.y) $display("FAIL basic_y got %h want %h", y_new, e.y); else passed++;
      total++; if (g_new !== e.g) $display("FAIL basic_g got %h want %h", g_new, e.g); else passed++;
      total++; if (prim_res !== 16'd60) $display("FAIL basic_res got %0d want 60", prim_res); else passed++;
      total++; if (y_new[W-1:0] !== 16'd65 || g_new[W-1:0] !== 16'hffe2) $display("FAIL basic_elem got %0d/%h want 65/ffe2", y_new[W-1:0], g_new[W-1:0]); else passed++;
      total++; if (sat_flag !== 1'b0) $display("FAIL basic_sat got %b want 0", sat_flag); else passed++;
      prev = e;
   endtask

   task automatic test_residual();
      int cyc;
      exp_t e;
      fill(10, 10, 1, 0, 0, 3);
      xs[7] = 500; vs[7] = -300; zs[2] = 900;
      launch();
      wait_done(cyc);
      e = sb.pop_front();
      total++; if (prim_res !== e.res || prim_res !== 16'd900) $display("FAIL resid_res got %0d want 900", prim_res); else passed++;
      total++; if (y_new[7*W +: W] !== 16'd801) $display("FAIL resid_y7 got %0d want 801", y_new[7*W +: W]); else passed++;
      total++; if (y_new !== e.y || g_new !== e.g) $display("FAIL resid_vec got %h %h want %h %h", y_new, g_new, e.y, e.g); else passed++;
      prev = e;
   endtask

   task automatic test_saturation();
      int cyc;
      exp_t e;
      fill(0, 0, 0, 0, 0, 0);
      ys[0] = 32000; xs[0] = 1000;
      launch();
      wait_done(cyc);
      e = sb.pop_front();
`ifdef DUAL_UPDATE_SAT_EN
      total++; if (y_new[W-1:0] !== 16'd32767 || sat_flag !== 1'b1) $display("FAIL sat_clamp got %0d/%b want 32767/1", $signed(y_new[W-1:0]), sat_flag); else passed++;
`else
      total++; if (y_new[W-1:0] !== 16'h80e8 || sat_flag !== 1'b0) $display("FAIL sat_wrap got %0d/%b want -32536/0", $signed(y_new[W-1:0]), sat_flag); else passed++;
`endif
      total++; if (y_new !== e.y || sat_flag !== e.sat || prim_res !== e.res) $display("FAIL sat_model got %h %b %0d want %h %b %0d", y_new, sat_flag, prim_res, e.y, e.sat, e.res); else passed++;
      prev = e;
   endtask

   task automatic test_busy_reject();
      exp_t e;
      int dones = 0, dcyc = 0;
      logic busy_ok = 1'b1;
      fill(7, 3, -2, 50, -50, 1);
      launch();
      for (int c = 1; c <= 22; c++) begin
         if (c <= 16 && busy !== 1'b1) busy_ok = 1'b0;
         if (c == 17 && busy !== 1'b0) busy_ok = 1'b0;
         if (done === 1'b1) begin dones++; dcyc = c; end
         if (c == 5) begin fill(999, -999, 77, 1, 2, 3); pack(); start = 1; end
         if (c == 6) start = 0;
         @(negedge clk);
      end
      e = sb.pop_front();
      total++; if (dones !== 1 || dcyc !== 17) $display("FAIL busy_done got %0d pulses at %0d want 1 at 17", dones, dcyc); else passed++;
      total++; if (busy_ok !== 1'b1) $display("FAIL busy_window got %b want 1", busy_ok); else passed++;
      total++; if (y_new !== e.y || g_new !== e.g || prim_res !== e.res) $display("FAIL busy_data got %h %h %0d want %h %h %0d", y_new, g_new, prim_res, e.y, e.g, e.res); else passed++;
      prev = e;
   endtask

   task automatic test_reset_mid();
      int cyc, dones = 0;
      exp_t e;
      fill(-40, 60, 9, 11, 22, -33);
      launch();
      repeat (7) @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      void'(sb.pop_back());
      total++; if ({y_new, g_new, prim_res} !== '0 || busy !== 1'b0) $display("FAIL midrst_clear got %h busy %b want 0", {y_new, g_new, prim_res}, busy); else passed++;
      for (int c = 0; c < 20; c++) begin
         if (done === 1'b1) dones++;
         @(negedge clk);
      end
      total++; if (dones !== 0) $display("FAIL midrst_nodone got %0d want 0", dones); else passed++;
      launch();
      wait_done(cyc);
      e = sb.pop_front();
      total++; if (cyc !== 17) $display("FAIL midrst_latency got %0d want 17", cyc); else passed++;
      total++; if (y_new !== e.y || g_new !== e.g || prim_res !== e.res) $display("FAIL midrst_data got %h %h %0d want %h %h %0d", y_new, g_new, prim_res, e.y, e.g, e.res); else passed++;
      prev = e;
   endtask

   task automatic test_extremes();
      int cyc;
      exp_t e;
      fill(-32768, 32767, 0, -32768, 32767, 0);
      launch();
      repeat (9) @(negedge clk);
      total++; if (y_new !== prev.y || prim_res !== prev.res) $display("FAIL ext_hold got %h %0d want %h %0d", y_new, prim_res, prev.y, prev.res); else passed++;
      wait_done(cyc);
      e = sb.pop_front();
      total++; if (prim_res !== 16'd32767) $display("FAIL ext_res got %0d want 32767", prim_res); else passed++;
`ifdef DUAL_UPDATE_SAT_EN
      total++; if (y_new[W-1:0] !== 16'h8000 || sat_flag !== 1'b1) $display("FAIL ext_y got %h/%b want 8000/1", y_new[W-1:0], sat_flag); else passed++;
`else
      total++; if (y_new[W-1:0] !== 16'h0001 || sat_flag !== 1'b0) $display("FAIL ext_y got %h/%b want 0001/0", y_new[W-1:0], sat_flag); else passed++;
`endif
      total++; if (y_new !== e.y || g_new !== e.g) $display("FAIL ext_vec got %h %h want %h %h", y_new, g_new, e.y, e.g); else passed++;
      prev = e;
   endtask

   task automatic test_back_to_back();
      int cyc, c;
      exp_t e;
      fill(3, -4, 100, -7, 8, -9);
      ys[11] = -5; us[3] = 400;
      @(negedge clk);
      pack();
      start = 1;
      sb.push_back(model());
      sb.push_back(model());
      @(negedge clk);
      wait_done(cyc);
      e = sb.pop_front();
      total++; if (cyc !== 17 || y_new !== e.y || g_new !== e.g || prim_res !== e.res) $display("FAIL b2b_first got cyc %0d res %0d want 17 %0d", cyc, prim_res, e.res); else passed++;
      c = cyc;
      do begin
         @(negedge clk);
         c++;
      end while (done !== 1'b1 && c < 60);
      start = 0;
      e = sb.pop_front();
      total++; if (c !== 35) $display("FAIL b2b_second_cycle got %0d want 35", c); else passed++;
      total++; if (y_new !== e.y || g_new !== e.g || prim_res !== e.res) $display("FAIL b2b_second_data got %h %0d want %h %0d", y_new, prim_res, e.y, e.res); else passed++;
      total++; if (sb.size() !== 0) $display("FAIL sb_empty got %0d want 0", sb.size()); else passed++;
   endtask

   initial begin
      fill(0, 0, 0, 0, 0, 0);
      pack();
      test_reset();
      test_basic();
      test_residual();
      test_saturation();
      test_busy_reject();
      test_reset_mid();
      test_extremes();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/dual_update.md
Name: dual_update

Overview:
- ADMM dual-variable update; the counterpart of the slack/projection stage in the per-knot MPC iteration.
- Consumes the primal iterate (x_k, u_k) and the clipped slacks (v_k, z_k) from the slack stage.
- Produces the updated scaled duals y_k_new = y_k + (x_k - v_k) and g_k_new = g_k + (u_k - z_k); these feed the next slack update.
- Also reports the primal residual max|x-v|, max|u-z| for convergence checks; elements are processed serially through one shared adder/comparator datapath.

Parameters:
- STATE_DIM, 12, number of state elements.
- CONTROL_DIM, 4, number of control elements.
- W, 16, signed fixed-point word width (all operands same Q format).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- start  input  1  request; samples all vector inputs on the accepting cycle.
- x_k  input  W x STATE_DIM  signed primal state.
- v_k  input  W x STATE_DIM  signed state slack.
- y_k  input  W x STATE_DIM  signed state dual (current).
- u_k  input  W x CONTROL_DIM  signed primal control.
- z_k  input  W x CONTROL_DIM  signed control slack.
- g_k  input  W x CONTROL_DIM  signed control dual (current).
- y_new  output  W x STATE_DIM  signed updated state dual.
- g_new  output  W x CONTROL_DIM  signed updated control dual.
- prim_res  output  W  unsigned-valued max |x-v| / |u-z| over all elements (MSB always 0).
- sat_flag  output  1  at least one element saturated during the last run.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: y_new, g_new, prim_res all zero; sat_flag=0; busy=0; done=0; FSM=IDLE; index=0.
- Reset mid-operation aborts the run (no done pulse); outputs return to their reset values.
- FSM states: IDLE, STATE_PASS, CTRL_PASS, FINISH.
- IDLE:
  - start=1 latches all six input vectors into internal registers.
  - Clears the running residual and sat accumulator; index<=0; busy<=1; goes to STATE_PASS.
- STATE_PASS: one element per cycle, i=index:
  - d = x[i]-v[i] computed in W+1 bits.
  - s = y[i]+d computed in W+2 bits, reduced to W bits per the saturation rule.
  - Result written to an internal y buffer.
  - |d| (W+1 bits) saturated to 2^(W-1)-1 and compared against the running max.
  - After index=STATE_DIM-1: index<=0, go to CTRL_PASS.
- CTRL_PASS: same computation on u/z/g into the g buffer; after index=CONTROL_DIM-1, go to FINISH.
- FINISH:
  - Copies the buffers to y_new/g_new, the running max to prim_res and the accumulated sat to sat_flag.
  - done=1 for exactly this cycle; busy<=0; returns to IDLE.
- Latency: start accepted at cycle 0 -> done high at cycle STATE_DIM+CONTROL_DIM+1 (17 with defaults).
- Outputs are updated only in FINISH; they hold their values between runs.
- start while busy=1 is ignored; it is neither queued nor re-latched. start in the FINISH cycle is ignored.
- start held high continuously gives back-to-back runs, each accepted in IDLE.
- |d| of the most-negative value is handled via the W+1-bit intermediate; no overflow.
- CONTROL_DIM=0 or STATE_DIM=0 is not supported; both must be >= 1.

Optional Feature:
- Macro: DUAL_UPDATE_SAT_EN.
- Defined:
  - y/g results clamp to [-2^(W-1), 2^(W-1)-1].
  - Any clamp sets the sat accumulator; sat_flag reports it in FINISH.
- Undefined:
  - Results take the low W bits (two's-complement wrap).
  - sat_flag is constant 0; the prim_res clamp is unaffected.

Test Plan:
- Basic update: all x=100, v=40, y=5, u=-20, z=10, g=0; start -> done at cycle 17; all y_new=65, all g_new=-30; prim_res=60; sat_flag=0.
- Residual max: x[7]=500, v[7]=-300 (others x=v); u[2]=0, z[2]=900 -> prim_res=900; y_new[7]=y[7]+800.
- Saturation with DUAL_UPDATE_SAT_EN, W=16: y[0]=32000, x[0]=1000, v[0]=0 -> y_new[0]=32767, sat_flag=1. Without the macro -> y_new[0]=-32536, sat_flag=0.
- Busy rejection: start at cycle 0, change the inputs and pulse start again at cycle 5 -> single done at cycle 17; results reflect the cycle-0 inputs; busy=1 for cycles 1-16.
- Reset mid-run: start, assert reset at cycle 8 for 1 cycle -> no done pulse; y_new/g_new/prim_res=0; busy=0. A following start completes 17 cycles later with correct results.
- Extremes: x=-32768, v=32767 -> |d| clamps, prim_res=32767; with the macro, y_new saturates to -32768 (y=0); outputs from the previous run are held until this run's FINISH.
